bus_if_gen: RTL
===============

// Module: bus_if_gen
// PURPOSE
//  Parametrised CPU-stage bus interface. Sits between one pipeline stage (IF or MEM) and both the
//  local SPM and the shared system bus. Decodes each access to the SPM (zero-wait) or the bus
//  (req/grant/strobe/ready handshake). Raises busy to stall the pipeline and holds read data
//  while the stage is stalled. Generalises width, SPM window and bus parking; adds an optional timeout.
// PARAMETERS
//  ADDR_W      30     word-address width
//  DATA_W      32     data width
//  SPM_ADDR_W  12     SPM word-address width (low bits of addr)
//  SPM_TAG     'h0    value of addr[ADDR_W-1 -: TAG_W] that selects the SPM; TAG_W = 3
//  BUS_PARK    0      1: keep bus_req_ low between back-to-back bus accesses
//  TIMEOUT_CYC 255    cycles in REQ+ACCESS before abort (only with BUS_IF_TIMEOUT_EN)
// PORTS
//  clk          in   1           system clock
//  reset        in   1           synchronous, active-high
//  stall        in   1           stage stall from cpu_ctrl
//  flush        in   1           stage flush from cpu_ctrl
//  addr         in   ADDR_W      access word address
//  as_          in   1           access strobe, active low
//  rw           in   1           1=READ, 0=WRITE
//  wr_data      in   DATA_W      write data
//  rd_data      out  DATA_W      read data to stage
//  busy         out  1           stage must stall
//  bus_err      out  1           one-cycle timeout pulse (0 without the macro)
//  spm_addr     out  SPM_ADDR_W  SPM address = addr[SPM_ADDR_W-1:0]
//  spm_as_      out  1           SPM strobe, active low
//  spm_rw / spm_wr_data  out 1 / DATA_W   pass-through of rw / wr_data
//  spm_rd_data  in   DATA_W      SPM read data
//  bus_req_     out  1           bus request, active low, registered
//  bus_grnt_    in   1           bus grant, active low
//  bus_addr / bus_rw / bus_wr_data  out ADDR_W / 1 / DATA_W   registered, latched at request
//  bus_as_      out  1           bus strobe, active low, registered, one cycle per access
//  bus_rdy_     in   1           slave ready, active low
//  bus_rd_data  in   DATA_W      bus read data
// BEHAVIOUR
//  Reset: state=IDLE; bus_req_=1, bus_as_=1, bus_rw=READ, bus_addr=0, bus_wr_data=0, rd_buf=0, bus_err=0.
//  Reset in any state returns to IDLE on the same edge; bus_req_/bus_as_ are high next cycle.
//  SPM hit (as_=0, tag==SPM_TAG, state IDLE): spm_as_=0 comb.; rd_data=spm_rd_data; busy=0.
//  flush=1 suppresses spm_as_ and starting a new bus access; an in-flight access completes.
//  IDLE: bus miss with flush=0 -> latch addr/rw/wr_data, bus_req_<=0, busy=1 comb., -> REQ.
//  REQ: busy=1; on bus_grnt_=0 -> bus_as_<=0 for exactly one cycle, -> ACCESS.
//  ACCESS: busy=1 until bus_rdy_=0. In that cycle: busy=0, rd_data=bus_rd_data (comb.),
//    rd_buf<=bus_rd_data, bus_req_<=1 (unless BUS_PARK); next state = stall ? STALL : IDLE.
//  STALL: busy=0, rd_data=rd_buf; stays while stall=1; -> IDLE when stall=0.
//  BUS_PARK=1: bus_req_ stays low leaving ACCESS. A bus miss in IDLE with bus_grnt_ still 0
//    skips REQ (bus_as_<=0 directly). Any SPM access or idle cycle drops bus_req_<=1.
//  Writes: rd_data undefined-free, driven 0 for bus writes; busy timing identical to reads.
//  rd_data=0 whenever no access is in progress and state is IDLE with as_=1.
// CONFIGURATION
//  `BUS_IF_TIMEOUT_EN defined: counter counts cycles in REQ/ACCESS and clears on entry to IDLE.
//    At count==TIMEOUT_CYC: state -> IDLE, bus_req_<=1, bus_as_<=1, bus_err=1 for that cycle,
//    busy=0, rd_data=0.
//  Not defined: no counter; REQ/ACCESS wait indefinitely; bus_err tied 0.
// STRUCTURE
//  bus_if_pkg: state encoding (IDLE/REQ/ACCESS/STALL), READ/WRITE, ENABLE_/DISABLE_ constants.
//  One sub-module: bus_if_wdt (timeout counter), instantiated only under BUS_IF_TIMEOUT_EN.
// TESTING
//  1 SPM read addr=tag 0, spm_rd_data=32'hA5A5_0001 -> same cycle rd_data=A5A50001, busy=0,
//    bus_req_=1.
//  2 Bus read addr=30'h1000_0004, grant after 2 cyc, rdy_ after 3 -> busy high 6 cyc,
//    rd_data=bus_rd_data, bus_as_ low exactly 1 cyc.
//  3 Bus read completing with stall=1 for 4 cyc, bus_rd_data changed to 0 afterwards ->
//    rd_data holds latched value until stall=0.
//  4 BUS_PARK=1, two back-to-back bus writes, grant held -> bus_req_ stays 0;
//    second bus_as_ one cycle after first rdy_.
//  5 reset=1 in ACCESS -> next cycle state IDLE, bus_req_=1, busy=0, rd_data=0.
//  6 BUS_IF_TIMEOUT_EN, TIMEOUT_CYC=8, grant never given -> bus_err pulse at cycle 8, busy=0,
//    bus_req_=1 next cycle.

Source files
------------

// File: rtl/bus_if_gen_pkg.sv
// +--------------------------------------------------------------------+
// | bus_if_gen_pkg : shared encodings for the stage bus interface      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package bus_if_gen_pkg;

  localparam int TAG_W = 3;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACCESS = 2'd2,
    ST_STALL  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bus_if_gen_if.sv
// +--------------------------------------------------------------------+
// | bus_if_gen_if : shared system-bus handshake (req/grant/strobe/rdy) |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface bus_if_gen_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);

  logic              bus_req_;
  logic              bus_grnt_;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wr_data;
  logic              bus_as_;
  logic              bus_rdy_;
  logic [DATA_W-1:0] bus_rd_data;

  modport master (
    output bus_req_, bus_addr, bus_rw, bus_wr_data, bus_as_,
    input  bus_grnt_, bus_rdy_, bus_rd_data
  );

  modport slave (
    input  bus_req_, bus_addr, bus_rw, bus_wr_data, bus_as_,
    output bus_grnt_, bus_rdy_, bus_rd_data
  );

endinterface

`default_nettype wire

// File: rtl/bus_if_gen_wdt.sv
// +--------------------------------------------------------------------+
// | bus_if_wdt : bus access timeout counter (exists with               |
// | BUS_IF_TIMEOUT_EN only)                       Rev 1.0              |
// +--------------------------------------------------------------------+
`default_nettype none

`ifdef BUS_IF_TIMEOUT_EN
module bus_if_wdt #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] count;

  // Counts completed cycles spent in REQ/ACCESS; never passes TIMEOUT_CYC
  // because expiry forces the FSM back to IDLE, which clears it.
  always_ff @(posedge clk) begin
    if (reset || !active) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = active && (count == CNT_W'(TIMEOUT_CYC));

endmodule
`endif

`default_nettype wire

// File: rtl/bus_if_gen.sv
// +--------------------------------------------------------------------+
// | bus_if_gen : pipeline-stage interface to local SPM and system bus  |
// | Optional timeout: BUS_IF_TIMEOUT_EN               Rev 1.0          |
// +--------------------------------------------------------------------+
`default_nettype none

module bus_if_gen
  import bus_if_gen_pkg::*;
#(
  parameter int               ADDR_W     = 30,
  parameter int               DATA_W     = 32,
  parameter int               SPM_ADDR_W = 12,
  parameter logic [TAG_W-1:0] SPM_TAG    = '0,
  parameter int               BUS_PARK   = 0
`ifdef BUS_IF_TIMEOUT_EN
  , parameter int             TIMEOUT_CYC = 255
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  as_,
  input  logic                  rw,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic                  bus_err,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [DATA_W-1:0]     spm_wr_data,
  input  logic [DATA_W-1:0]     spm_rd_data,
  bus_if_gen_if.master          bus
);

  state_t              state;
  logic                req_reg;
  logic                as_reg;
  logic                rw_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rd_buf;

  logic tag_hit;
  logic spm_hit;
  logic bus_miss;
  logic park_hit;
  logic timeout;

  assign tag_hit  = (addr[ADDR_W-1 -: TAG_W] == SPM_TAG);
  assign spm_hit  = (state == ST_IDLE) && (as_ == ENABLE_) && tag_hit && !flush;
  assign bus_miss = (state == ST_IDLE) && (as_ == ENABLE_) && !tag_hit && !flush;
  // A still-parked request with grant retained lets a new miss strobe immediately.
  assign park_hit = (BUS_PARK != 0) && (req_reg == ENABLE_) && (bus.bus_grnt_ == ENABLE_);

  assign spm_addr    = addr[SPM_ADDR_W-1:0];
  assign spm_as_     = spm_hit ? ENABLE_ : DISABLE_;
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;

  assign bus.bus_req_    = req_reg;
  assign bus.bus_as_     = as_reg;
  assign bus.bus_rw      = rw_reg;
  assign bus.bus_addr    = addr_reg;
  assign bus.bus_wr_data = wdata_reg;

`ifdef BUS_IF_TIMEOUT_EN
  logic wdt_active;
  assign wdt_active = (state == ST_REQ) || (state == ST_ACCESS);

  bus_if_wdt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdt (
    .clk     (clk),
    .reset   (reset),
    .active  (wdt_active),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  assign bus_err = timeout;

  always_comb begin
    busy    = 1'b0;
    rd_data = '0;
    if (!timeout) begin
      case (state)
        ST_IDLE: begin
          busy = bus_miss;
          if (spm_hit) rd_data = spm_rd_data;
        end
        ST_REQ:  busy = 1'b1;
        ST_ACCESS: begin
          if (bus.bus_rdy_ == ENABLE_) begin
            if (rw_reg == READ) rd_data = bus.bus_rd_data;
          end else begin
            busy = 1'b1;
          end
        end
        ST_STALL: rd_data = rd_buf;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_reg   <= DISABLE_;
      as_reg    <= DISABLE_;
      rw_reg    <= READ;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rd_buf    <= '0;
    end else if (timeout) begin
      state   <= ST_IDLE;
      req_reg <= DISABLE_;
      as_reg  <= DISABLE_;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus_miss) begin
            addr_reg  <= addr;
            rw_reg    <= rw;
            wdata_reg <= wr_data;
            if (park_hit) begin
              as_reg <= ENABLE_;
              state  <= ST_ACCESS;
            end else begin
              req_reg <= ENABLE_;
              state   <= ST_REQ;
            end
          end else begin
            req_reg <= DISABLE_;
          end
        end
        ST_REQ: begin
          if (bus.bus_grnt_ == ENABLE_) begin
            as_reg <= ENABLE_;
            state  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          as_reg <= DISABLE_;
          if (bus.bus_rdy_ == ENABLE_) begin
            rd_buf <= (rw_reg == WRITE) ? '0 : bus.bus_rd_data;
            if (BUS_PARK == 0) req_reg <= DISABLE_;
            state <= stall ? ST_STALL : ST_IDLE;
          end
        end
        ST_STALL: begin
          if (!stall) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
